// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [15:0] NOP_OPCODE       = 16'h0800;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [15:0] PC_INC           = 16'd2;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - 16-bit register with synchronous reset-to-value and load enable
module pc_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en_i,
    input  logic [15:0] load_val_i,
    output logic [15:0] value_o
);

    logic [15:0] value_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= RESET_VAL;
        end else if (load_en_i) begin
            value_q <= load_val_i;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: PC, memory handshake and one-entry instruction buffer
module fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [15:0] NOP_INSTR = NOP_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    input  logic        stall,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        halted
);

    localparam logic [15:0] RESET_PC_EVEN = RESET_PC & 16'hFFFE;

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_reg_q;
    logic [15:0]  pc_reg_d;
    logic [15:0]  instr_q;
    logic [15:0]  pc_plus2_q;
    logic         take_redirect;
    logic         latch;

    // Redirect outranks a same-cycle memory response; HALTED ignores it entirely.
    assign take_redirect = redirect && (state_q != HALTED);
    assign latch         = (state_q == FETCH) && imem_ready && !redirect;
    assign pc_reg_d      = take_redirect ? (redirect_pc & 16'hFFFE) : (pc_reg_q + PC_INC);

    pc_reg #(.RESET_VAL(RESET_PC_EVEN)) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .load_en_i  (take_redirect || latch),
        .load_val_i (pc_reg_d),
        .value_o    (pc_reg_q)
    );

    pc_reg #(.RESET_VAL(16'h0000)) u_pc_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en_i  (latch),
        .load_val_i (pc_reg_q),
        .value_o    (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
        end else if (latch) begin
            instr_q    <= imem_data;
            pc_plus2_q <= pc_reg_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (!redirect && imem_ready) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (redirect) begin
                    state_d = FETCH;
                end else if (!stall) begin
                    state_d = halt ? HALTED : FETCH;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == FETCH);
        instr_valid = (state_q == VALID);
        halted      = (state_q == HALTED);
        instr       = instr_valid ? instr_q : NOP_INSTR;
    end

    assign imem_addr = pc_reg_q;
    assign pc_plus2  = pc_plus2_q;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - randomized and directed self-checking bench for the fetch stage
module tb_fetch;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        stall;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Reference: "have" = an instruction is buffered, "stopped" = HALT consumed.
    bit          m_have;
    bit          m_stopped;
    logic [15:0] m_next;
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic [15:0] m_pc2;

    fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .stall       (stall),
        .instr       (instr),
        .pc          (pc),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_have = 0; m_stopped = 0; m_next = 16'h0000;
            m_instr = NOP; m_pc = 16'h0000; m_pc2 = 16'h0000;
        end else if (m_stopped) begin
        end else if (redirect) begin
            m_next = {redirect_pc[15:1], 1'b0};
            m_have = 0;
        end else if (!m_have) begin
            if (imem_ready) begin
                m_instr = imem_data;
                m_pc    = m_next;
                m_pc2   = 16'(m_next + 16'd2);
                m_next  = 16'(m_next + 16'd2);
                m_have  = 1;
            end
        end else if (!stall) begin
            m_have = 0;
            if (halt) m_stopped = 1;
        end
    endtask

    task automatic step(input bit r, input bit rdy, input logic [15:0] data,
                        input bit rd, input logic [15:0] rdpc, input bit h, input bit st);
        @(negedge clk);
        rst = r; imem_ready = rdy; imem_data = data;
        redirect = rd; redirect_pc = rdpc; halt = h; stall = st;
        @(posedge clk);
        #1;
        model_update();
        check("imem_req",    {15'd0, imem_req},    {15'd0, !m_have && !m_stopped});
        check("imem_addr",   imem_addr,            m_next);
        check("instr_valid", {15'd0, instr_valid}, {15'd0, m_have});
        check("halted",      {15'd0, halted},      {15'd0, m_stopped});
        check("instr",       instr,                m_have ? m_instr : NOP);
        check("pc",          pc,                   m_pc);
        check("pc_plus2",    pc_plus2,             m_pc2);
    endtask

    initial begin
        rst = 1; imem_ready = 0; imem_data = 0; redirect = 0;
        redirect_pc = 0; halt = 0; stall = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_addr",  imem_addr, 16'h0000);
        check("reset_instr", instr, NOP);

        // Back-to-back fetch, memory always ready.
        for (int i = 1; i <= 6; i++) step(0, 1, 16'h4000 + 16'(i), 0, 0, 0, 0);
        check("seq_addr", imem_addr, 16'h0006);

        // Three wait cycles then a response.
        for (int i = 0; i < 3; i++) step(0, 0, 16'hDEAD, 0, 0, 0, 0);
        step(0, 1, 16'h1234, 0, 0, 0, 0);
        check("wait_instr", instr, 16'h1234);

        // Stall five cycles while valid, then consume.
        for (int i = 0; i < 5; i++) step(0, 1, 16'hBEEF, 0, 0, 0, 1);
        check("stall_pc", pc, 16'h0006);
        step(0, 1, 16'hBEEF, 0, 0, 0, 0);

        // Redirect in the same cycle as imem_ready.
        step(0, 1, 16'h5555, 1, 16'h0101, 0, 0);
        check("redir_addr", imem_addr, 16'h0100);

        // Wrap at 16'hFFFE.
        step(0, 0, 0, 1, 16'hFFFE, 0, 0);
        step(0, 1, 16'h7777, 0, 0, 0, 0);
        check("wrap_addr", imem_addr, 16'h0000);
        check("wrap_pc2",  pc_plus2,  16'h0000);
        step(0, 0, 0, 0, 0, 0, 0);

        // HALT consumed at 0x0010, later redirect ignored, then reset.
        step(0, 0, 0, 1, 16'h0010, 0, 0);
        step(0, 1, 16'h0F00, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("halt_flag", {15'd0, halted}, 16'd1);
        step(0, 1, 0, 1, 16'h0200, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("halt_rst_addr", imem_addr, 16'h0000);

        // Reset in the middle of a wait.
        step(0, 1, 16'h2222, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 16'($urandom),
                 $urandom_range(0, 7) == 0,
                 16'($urandom),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
